// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/sequencing controller for the five-stage pipeline.
// Ports: clk_i, rst_ni; inputs je_i, jump_addr_i, ex_mem_re_i,
//   ex_rd_addr_i, id_rs{1,2}_addr_i, id_rs{1,2}_re_i, dmem_busy_i.
// Outputs: stall_{if,id,ex,mem}_o, flush_{id,ex}_o, pc_we_o,
//   pc_next_o, state_o.
// Optional macro PIPE_PERF_CNT_EN adds stall_cnt_o and flush_cnt_o.
module pipe_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int LU_STALL     = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            je_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic            ex_mem_re_i,
    input  logic [4:0]      ex_rd_addr_i,
    input  logic [4:0]      id_rs1_addr_i,
    input  logic [4:0]      id_rs2_addr_i,
    input  logic            id_rs1_re_i,
    input  logic            id_rs2_re_i,
    input  logic            dmem_busy_i,
    output logic            stall_if_o,
    output logic            stall_id_o,
    output logic            stall_ex_o,
    output logic            stall_mem_o,
    output logic            flush_id_o,
    output logic            flush_ex_o,
    output logic            pc_we_o,
    output logic [XLEN-1:0] pc_next_o,
    output logic [1:0]      state_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o
`endif
);

    localparam int MAXC = (FLUSH_CYCLES > LU_STALL) ? FLUSH_CYCLES : LU_STALL;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] FC_LOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] LU_LOAD = CW'(LU_STALL - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        FLUSH  = 2'd2,
        MWAIT  = 2'd3
    } state_t;

    state_t            state_q, state_n;
    logic [CW-1:0]     cnt_q, cnt_n;
    logic              pend_q, pend_n;
    logic [XLEN-1:0]   pend_addr_q, pend_addr_n;

    logic              hazard;
    logic              full_stall, redir, bub_out, bub_start;
    logic              hold_flush, count_down;
    logic [XLEN-1:0]   redir_addr;

    logic              s_if, s_id, s_ex, s_mem, f_id, f_ex, we;
    logic [XLEN-1:0]   pc_n;

    assign hazard = ex_mem_re_i && (ex_rd_addr_i != 5'd0) &&
                    ((id_rs1_re_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                     (id_rs2_re_i && (id_rs2_addr_i == ex_rd_addr_i)));

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        pend_n      = pend_q;
        pend_addr_n = pend_addr_q;
        full_stall  = 1'b0;
        redir       = 1'b0;
        redir_addr  = '0;
        bub_out     = 1'b0;
        bub_start   = 1'b0;
        hold_flush  = 1'b0;
        count_down  = 1'b0;

        unique case (state_q)
            MWAIT: begin
                // EX is frozen, so a je_i seen here is stale and ignored.
                if (dmem_busy_i) begin
                    full_stall = 1'b1;
                end else if (pend_q) begin
                    redir      = 1'b1;
                    redir_addr = pend_addr_q;
                    pend_n     = 1'b0;
                end else begin
                    state_n = RUN;
                end
            end
            default: begin
                if (dmem_busy_i) begin
                    full_stall = 1'b1;
                    state_n    = MWAIT;
                    // A redirect coinciding with the freeze is replayed later.
                    if (je_i) begin
                        pend_n      = 1'b1;
                        pend_addr_n = jump_addr_i;
                    end
                end else if (je_i) begin
                    redir      = 1'b1;
                    redir_addr = jump_addr_i;
                end else if (state_q == BUBBLE) begin
                    bub_out    = 1'b1;
                    count_down = 1'b1;
                end else if (state_q == FLUSH) begin
                    hold_flush = 1'b1;
                    count_down = 1'b1;
                end else if (hazard) begin
                    bub_out   = 1'b1;
                    bub_start = 1'b1;
                end
            end
        endcase

        if (redir) begin
            if (FLUSH_CYCLES > 1) begin
                cnt_n   = FC_LOAD;
                state_n = FLUSH;
            end else begin
                state_n = RUN;
            end
        end

        if (bub_start && (LU_STALL > 1)) begin
            cnt_n   = LU_LOAD;
            state_n = BUBBLE;
        end

        if (count_down) begin
            cnt_n = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
            if (cnt_q <= 1) begin
                state_n = RUN;
            end
        end
    end

    assign s_if  = full_stall | bub_out;
    assign s_id  = full_stall | bub_out;
    assign s_ex  = full_stall;
    assign s_mem = full_stall;
    assign f_id  = redir | hold_flush;
    assign f_ex  = redir | hold_flush | bub_out;
    assign we    = redir;
    assign pc_n  = redir ? redir_addr : '0;

    // Outputs are Mealy; gating with rst_ni keeps them quiet during reset.
    assign stall_if_o  = rst_ni & s_if;
    assign stall_id_o  = rst_ni & s_id;
    assign stall_ex_o  = rst_ni & s_ex;
    assign stall_mem_o = rst_ni & s_mem;
    assign flush_id_o  = rst_ni & f_id;
    assign flush_ex_o  = rst_ni & f_ex;
    assign pc_we_o     = rst_ni & we;
    assign pc_next_o   = rst_ni ? pc_n : '0;
    assign state_o     = state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            pend_q      <= pend_n;
            pend_addr_q <= pend_addr_n;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_if_o) stall_cnt_o <= stall_cnt_o + 32'd1;
            if (flush_id_o) flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl.
// u2 uses FLUSH_CYCLES=LU_STALL=2; u1 uses the defaults (1/1).
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        je;
    logic [31:0] addr;
    logic        ld;
    logic [4:0]  ex_rd, rs1, rs2;
    logic        rs1_re, rs2_re;
    logic        busy;

    logic        a_sif, a_sid, a_sex, a_smem, a_fid, a_fex, a_we;
    logic [31:0] a_pc;
    logic [1:0]  a_st;
    logic        b_sif, b_sid, b_sex, b_smem, b_fid, b_fex, b_we;
    logic [31:0] b_pc;
    logic [1:0]  b_st;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] a_sc, a_fc, b_sc, b_fc;
`endif

    logic [6:0]  ctl, ctl1;
    int          n_chk  = 0;
    int          n_fail = 0;

    assign ctl  = {a_sif, a_sid, a_sex, a_smem, a_fid, a_fex, a_we};
    assign ctl1 = {b_sif, b_sid, b_sex, b_smem, b_fid, b_fex, b_we};

    always #5 clk = ~clk;

    pipe_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .LU_STALL(2)) u2 (
        .clk_i(clk), .rst_ni(rst_ni), .je_i(je), .jump_addr_i(addr),
        .ex_mem_re_i(ld), .ex_rd_addr_i(ex_rd),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .id_rs1_re_i(rs1_re), .id_rs2_re_i(rs2_re),
        .dmem_busy_i(busy),
        .stall_if_o(a_sif), .stall_id_o(a_sid), .stall_ex_o(a_sex),
        .stall_mem_o(a_smem), .flush_id_o(a_fid), .flush_ex_o(a_fex),
        .pc_we_o(a_we), .pc_next_o(a_pc), .state_o(a_st)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt_o(a_sc), .flush_cnt_o(a_fc)
`endif
    );

    pipe_ctrl u1 (
        .clk_i(clk), .rst_ni(rst_ni), .je_i(je), .jump_addr_i(addr),
        .ex_mem_re_i(ld), .ex_rd_addr_i(ex_rd),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .id_rs1_re_i(rs1_re), .id_rs2_re_i(rs2_re),
        .dmem_busy_i(busy),
        .stall_if_o(b_sif), .stall_id_o(b_sid), .stall_ex_o(b_sex),
        .stall_mem_o(b_smem), .flush_id_o(b_fid), .flush_ex_o(b_fex),
        .pc_we_o(b_we), .pc_next_o(b_pc), .state_o(b_st)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt_o(b_sc), .flush_cnt_o(b_fc)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        je = 0; addr = 0; ld = 0; ex_rd = 0; rs1 = 0; rs2 = 0;
        rs1_re = 0; rs2_re = 0; busy = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ld = 1; ex_rd = rd; rs1 = 5; rs1_re = 1;
    endtask

    task automatic test_reset;
        rst_ni = 0;
        idle();
        je = 1; addr = 32'h100; set_lu(5); busy = 0;
        #2;
        n_chk++; if (ctl !== 7'b0) begin n_fail++; $display("FAIL rst_ctl got=%b exp=%b", ctl, 7'b0); end
        n_chk++; if (a_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got=%h exp=0", a_pc); end
        n_chk++; if (a_st !== 2'd0) begin n_fail++; $display("FAIL rst_state got=%0d exp=0", a_st); end
        n_chk++; if (ctl1 !== 7'b0) begin n_fail++; $display("FAIL rst_ctl_u1 got=%b exp=0", ctl1); end
        idle();
        #2 rst_ni = 1;
        tick();
        #2;
        n_chk++; if (ctl !== 7'b0 || a_st !== 2'd0) begin n_fail++; $display("FAIL rst_release got=%b/%0d exp=0/0", ctl, a_st); end
        tick();
    endtask

    task automatic test_load_use;
        idle(); set_lu(5);
        #2;
        n_chk++; if (ctl !== 7'b1100010) begin n_fail++; $display("FAIL lu_c0 got=%b exp=1100010", ctl); end
        n_chk++; if (ctl1 !== 7'b1100010) begin n_fail++; $display("FAIL lu_c0_u1 got=%b exp=1100010", ctl1); end
        tick(); idle(); #2;
        n_chk++; if (a_st !== 2'd1) begin n_fail++; $display("FAIL lu_c1_state got=%0d exp=1", a_st); end
        n_chk++; if (ctl !== 7'b1100010) begin n_fail++; $display("FAIL lu_c1 got=%b exp=1100010", ctl); end
        n_chk++; if (ctl1 !== 7'b0 || b_st !== 2'd0) begin n_fail++; $display("FAIL lu_c1_u1 got=%b/%0d exp=0/0", ctl1, b_st); end
        tick(); #2;
        n_chk++; if (ctl !== 7'b0 || a_st !== 2'd0) begin n_fail++; $display("FAIL lu_c2 got=%b/%0d exp=0/0", ctl, a_st); end
        set_lu(0); #2;
        n_chk++; if (ctl !== 7'b0) begin n_fail++; $display("FAIL lu_x0 got=%b exp=0", ctl); end
        idle(); ld = 1; ex_rd = 7; rs2 = 7; rs2_re = 1; #2;
        n_chk++; if (ctl !== 7'b1100010) begin n_fail++; $display("FAIL lu_rs2 got=%b exp=1100010", ctl); end
        rs2_re = 0; #2;
        n_chk++; if (ctl !== 7'b0) begin n_fail++; $display("FAIL lu_rs2_nore got=%b exp=0", ctl); end
        idle(); ex_rd = 5; rs1 = 5; rs1_re = 1; #2;
        n_chk++; if (ctl !== 7'b0) begin n_fail++; $display("FAIL lu_noload got=%b exp=0", ctl); end
        idle(); tick();
    endtask

    task automatic test_redirect;
        idle(); je = 1; addr = 32'h100; #2;
        n_chk++; if (ctl !== 7'b0000111) begin n_fail++; $display("FAIL rd_c0 got=%b exp=0000111", ctl); end
        n_chk++; if (a_pc !== 32'h100) begin n_fail++; $display("FAIL rd_c0_pc got=%h exp=100", a_pc); end
        n_chk++; if (ctl1 !== 7'b0000111) begin n_fail++; $display("FAIL rd_c0_u1 got=%b exp=0000111", ctl1); end
        tick(); idle(); #2;
        n_chk++; if (ctl !== 7'b0000110 || a_st !== 2'd2) begin n_fail++; $display("FAIL rd_c1 got=%b/%0d exp=0000110/2", ctl, a_st); end
        n_chk++; if (a_pc !== 32'h0) begin n_fail++; $display("FAIL rd_c1_pc got=%h exp=0", a_pc); end
        n_chk++; if (ctl1 !== 7'b0 || b_st !== 2'd0) begin n_fail++; $display("FAIL rd_c1_u1 got=%b/%0d exp=0/0", ctl1, b_st); end
        tick(); #2;
        n_chk++; if (ctl !== 7'b0 || a_st !== 2'd0) begin n_fail++; $display("FAIL rd_c2 got=%b/%0d exp=0/0", ctl, a_st); end
        tick();
    endtask

    task automatic test_mwait;
        idle(); busy = 1; je = 1; addr = 32'h200; #2;
        n_chk++; if (ctl !== 7'b1111000 || a_pc !== 32'h0) begin n_fail++; $display("FAIL mw_c0 got=%b/%h exp=1111000/0", ctl, a_pc); end
        tick(); je = 0; addr = 0; #2;
        n_chk++; if (ctl !== 7'b1111000 || a_st !== 2'd3) begin n_fail++; $display("FAIL mw_c1 got=%b/%0d exp=1111000/3", ctl, a_st); end
        tick(); #2;
        n_chk++; if (ctl !== 7'b1111000 || a_st !== 2'd3) begin n_fail++; $display("FAIL mw_c2 got=%b/%0d exp=1111000/3", ctl, a_st); end
        tick(); busy = 0; #2;
        n_chk++; if (ctl !== 7'b0000111) begin n_fail++; $display("FAIL mw_rel got=%b exp=0000111", ctl); end
        n_chk++; if (a_pc !== 32'h200) begin n_fail++; $display("FAIL mw_rel_pc got=%h exp=200", a_pc); end
        n_chk++; if (ctl1 !== 7'b0000111 || b_pc !== 32'h200) begin n_fail++; $display("FAIL mw_rel_u1 got=%b/%h exp=0000111/200", ctl1, b_pc); end
        tick(); #2;
        n_chk++; if (ctl !== 7'b0000110 || a_st !== 2'd2) begin n_fail++; $display("FAIL mw_fl got=%b/%0d exp=0000110/2", ctl, a_st); end
        n_chk++; if (b_st !== 2'd0) begin n_fail++; $display("FAIL mw_fl_u1 got=%0d exp=0", b_st); end
        tick(); #2;
        n_chk++; if (a_st !== 2'd0) begin n_fail++; $display("FAIL mw_end got=%0d exp=0", a_st); end
        busy = 1; tick(); je = 1; addr = 32'h300; #2;
        n_chk++; if (ctl !== 7'b1111000) begin n_fail++; $display("FAIL mw_jeign got=%b exp=1111000", ctl); end
        tick(); idle(); #2;
        n_chk++; if (ctl !== 7'b0 || a_st !== 2'd3) begin n_fail++; $display("FAIL mw_nopend got=%b/%0d exp=0/3", ctl, a_st); end
        tick(); #2;
        n_chk++; if (a_st !== 2'd0) begin n_fail++; $display("FAIL mw_nopend_st got=%0d exp=0", a_st); end
        tick();
    endtask

    task automatic test_priority;
        idle(); set_lu(5); je = 1; addr = 32'h40; #2;
        n_chk++; if (ctl !== 7'b0000111 || a_pc !== 32'h40) begin n_fail++; $display("FAIL pr_rd got=%b/%h exp=0000111/40", ctl, a_pc); end
        tick(); idle(); #2;
        n_chk++; if (a_st !== 2'd2) begin n_fail++; $display("FAIL pr_state got=%0d exp=2", a_st); end
        tick(); tick(); set_lu(5); #2;
        tick(); idle(); je = 1; addr = 32'h80; #2;
        n_chk++; if (ctl !== 7'b0000111 || a_pc !== 32'h80) begin n_fail++; $display("FAIL pr_bubabort got=%b/%h exp=0000111/80", ctl, a_pc); end
        tick(); idle(); #2;
        n_chk++; if (a_st !== 2'd2) begin n_fail++; $display("FAIL pr_bubabort_st got=%0d exp=2", a_st); end
        je = 1; addr = 32'hC0; #2;
        n_chk++; if (ctl !== 7'b0000111 || a_pc !== 32'hC0) begin n_fail++; $display("FAIL pr_reflush got=%b/%h exp=0000111/c0", ctl, a_pc); end
        tick(); idle(); #2;
        n_chk++; if (ctl !== 7'b0000110 || a_st !== 2'd2) begin n_fail++; $display("FAIL pr_reload got=%b/%0d exp=0000110/2", ctl, a_st); end
        tick(); tick();
    endtask

    task automatic test_reset_mid;
        idle(); je = 1; addr = 32'h100;
        tick(); idle(); je = 1; addr = 32'h140; #1;
        rst_ni = 0; #1;
        n_chk++; if (ctl !== 7'b0 || a_pc !== 32'h0) begin n_fail++; $display("FAIL rm_out got=%b/%h exp=0/0", ctl, a_pc); end
        n_chk++; if (a_st !== 2'd0) begin n_fail++; $display("FAIL rm_state got=%0d exp=0", a_st); end
        idle(); #1 rst_ni = 1;
        tick(); #2;
        n_chk++; if (ctl !== 7'b0 || a_st !== 2'd0) begin n_fail++; $display("FAIL rm_after got=%b/%0d exp=0/0", ctl, a_st); end
        tick();
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic test_perf;
        idle(); rst_ni = 0; #2 rst_ni = 1;
        tick(); set_lu(5);
        tick(); idle();
        tick(); je = 1; addr = 32'h100;
        tick(); idle();
        tick(); #2;
        n_chk++; if (a_sc !== 32'd2 || a_fc !== 32'd2) begin n_fail++; $display("FAIL perf_u2 got=%0d/%0d exp=2/2", a_sc, a_fc); end
        n_chk++; if (b_sc !== 32'd1 || b_fc !== 32'd1) begin n_fail++; $display("FAIL perf_u1 got=%0d/%0d exp=1/1", b_sc, b_fc); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_mwait();
        test_priority();
        test_reset_mid();
`ifdef PIPE_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
